// File: rtl/piso_tx_sequencer_if.sv
// Word-in / frame-out bundle for piso_tx_sequencer: producer handshake, the
// external PISO register's pins, and the framed serial line with its status.
interface piso_tx_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] piso_data;
    logic             piso_load;
    logic             piso_serial;
    logic             tx_out;
    logic             busy;
    logic             frame_done;

    // The sequencer is the slave; producer/register/line side is the master.
    modport slave (
        input  in_data,
        input  in_valid,
        input  piso_serial,
        output in_ready,
        output piso_data,
        output piso_load,
        output tx_out,
        output busy,
        output frame_done
    );

    modport master (
        output in_data,
        output in_valid,
        output piso_serial,
        input  in_ready,
        input  piso_data,
        input  piso_load,
        input  tx_out,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/piso_tx_sequencer.sv
// Frame controller for an external right-shift PISO register: start, WIDTH data bits LSB first,
// optional parity (define PIPO_TX_PARITY_EN), then STOP_BITS stop bits.
module piso_tx_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    piso_tx_sequencer_if.slave    bus
);

    // Counter covers both the data bit index and the stop-bit index (up to 4).
    localparam int unsigned CntW = $clog2(WIDTH > 4 ? WIDTH : 4);

    if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop_bits
        $error("piso_tx_sequencer: STOP_BITS=%0d outside 1..4", STOP_BITS);
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("piso_tx_sequencer: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hold_q, hold_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.piso_data = hold_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        bus.in_ready   = 1'b0;
        bus.tx_out     = 1'b1;
        bus.piso_load  = 1'b1;
        bus.busy       = 1'b1;
        bus.frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    hold_d  = bus.in_data;
                    state_d = StStart;
                end
            end
            StStart: begin
                // Register loads hold on this edge so DATA cycle 0 sees hold[0].
                bus.tx_out = 1'b0;
                cnt_d      = '0;
                state_d    = StData;
            end
            StData: begin
                bus.piso_load = 1'b0;
                bus.tx_out    = bus.piso_serial;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d = '0;
`ifdef PIPO_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: begin
`ifdef PIPO_TX_PARITY_EN
                bus.tx_out = (^hold_q) ^ (PARITY_ODD != 0);
                state_d    = StStop;
`else
                state_d    = StIdle;
`endif
            end
            StStop: begin
                if (cnt_q == CntW'(STOP_BITS - 1)) begin
                    bus.frame_done = 1'b1;
                    cnt_d          = '0;
                    state_d        = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

endmodule
